// File: rtl/conv2d_engine.sv
// conv2d_engine
//   2-D "same" convolution engine. A KxK signed filter (K = 3 or 5) is
//   loaded, then an NxN signed image, then NxN results are streamed in
//   raster order. Each result is a full-precision sum of products, then
//   optional ReLU, then saturation to OUT_W bits. Out-of-image taps read
//   zero or the clamped edge pixel, depending on pad_mode.
//
// Ports
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset (aborts any job)
//   filter_valid  in_data carries a filter coefficient (row-major)
//   image_valid   in_data carries an image pixel (row-major)
//   filter_size   0 = 3x3, 1 = 5x5         (latched with coefficient 0)
//   image_size    image side N, clamped to [3, MAX_N] (latched likewise)
//   pad_mode      0 = zero pad, 1 = replicate edge (latched likewise)
//   act_mode      0 = pass-through, 1 = ReLU      (latched likewise)
//   in_data       signed sample
//   out_valid     qualifies out_data
//   out_data      signed, activated and saturated result
module conv2d_engine #(
    parameter int DATA_W = 8,
    parameter int MAX_N  = 8,
    parameter int OUT_W  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         filter_valid,
    input  logic                         image_valid,
    input  logic                         filter_size,
    input  logic [$clog2(MAX_N+1)-1:0]   image_size,
    input  logic                         pad_mode,
    input  logic                         act_mode,
    input  logic signed [DATA_W-1:0]     in_data,
    output logic                         out_valid,
    output logic signed [OUT_W-1:0]      out_data
);

    localparam int NW    = $clog2(MAX_N + 1);
    localparam int RW    = $clog2(MAX_N);
    localparam int PW    = 2 * DATA_W;
    localparam int ACC_W = 2 * DATA_W + 5;
    localparam int SW    = (ACC_W > OUT_W) ? ACC_W : OUT_W;

    localparam logic signed [SW-1:0] SAT_MAX = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_FILTER  = 2'd1;
    localparam logic [1:0] S_IMAGE   = 2'd2;
    localparam logic [1:0] S_COMPUTE = 2'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]              state_q,    state_d;
    logic                    fsize_q,    fsize_d;
    logic                    pad_q,      pad_d;
    logic                    act_q,      act_d;
    logic [NW-1:0]           n_q,        n_d;
    logic [2:0]              fi_q,       fi_d;
    logic [2:0]              fj_q,       fj_d;
    logic                    fdone_q,    fdone_d;
    logic [RW-1:0]           lr_q,       lr_d;
    logic [RW-1:0]           lc_q,       lc_d;
    logic [RW-1:0]           r_q,        r_d;
    logic [RW-1:0]           c_q,        c_d;
    logic                    issued_q,   issued_d;
    logic                    s1_valid_q, s1_valid_d;
    logic signed [ACC_W-1:0] acc_q,      acc_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0] out_data_q,  out_data_d;

    logic signed [DATA_W-1:0] filt_q  [5][5];
    logic signed [DATA_W-1:0] image_q [MAX_N][MAX_N];

    // Buffer write controls produced by the FSM
    logic          filt_clr;
    logic          filt_we;
    logic [2:0]    filt_wi;
    logic [2:0]    filt_wj;
    logic          img_we;
    logic [RW-1:0] img_wr;
    logic [RW-1:0] img_wc;

    logic [NW-1:0]           n_clamp;
    logic [2:0]              k_last;
    logic [RW-1:0]           n_last;
    logic signed [ACC_W-1:0] win_sum;
    logic signed [SW-1:0]    acc_ext;
    logic signed [SW-1:0]    act_v;
    logic signed [OUT_W-1:0] sat_v;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    always_comb begin
        if (image_size < NW'(3)) begin
            n_clamp = NW'(3);
        end else if (image_size > NW'(MAX_N)) begin
            n_clamp = NW'(MAX_N);
        end else begin
            n_clamp = image_size;
        end
    end

    assign k_last = fsize_q ? 3'd4 : 3'd2;
    assign n_last = RW'(n_q - NW'(1));

    // ------------------------------------------------------------------
    // Window sum for output position (r_q, c_q). Coordinates are always
    // clamped so the buffer index stays legal; zero padding then masks
    // the pixel rather than steering the index.
    // ------------------------------------------------------------------
    always_comb begin : window_sum
        int kk;
        int hh;
        int nn;
        int rr;
        int cc;
        logic inside_v;
        logic signed [DATA_W-1:0] px;
        logic signed [PW-1:0]     prod;

        win_sum  = '0;
        kk       = fsize_q ? 5 : 3;
        hh       = fsize_q ? 2 : 1;
        nn       = int'(n_q);
        rr       = 0;
        cc       = 0;
        inside_v = 1'b0;
        px       = '0;
        prod     = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            for (int unsigned j = 0; j < 5; j++) begin
                rr = int'(r_q) + int'(i) - hh;
                cc = int'(c_q) + int'(j) - hh;
                inside_v = (rr >= 0) && (rr < nn) && (cc >= 0) && (cc < nn);
                if (rr < 0) begin
                    rr = 0;
                end else if (rr > nn - 1) begin
                    rr = nn - 1;
                end
                if (cc < 0) begin
                    cc = 0;
                end else if (cc > nn - 1) begin
                    cc = nn - 1;
                end
                px = image_q[RW'(rr)][RW'(cc)];
                if (!inside_v && !pad_q) begin
                    px = '0;
                end
                prod = px * filt_q[3'(i)][3'(j)];
                if ((int'(i) < kk) && (int'(j) < kk)) begin
                    win_sum = win_sum + {{(ACC_W-PW){prod[PW-1]}}, prod};
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Activation and saturation of the registered sum
    // ------------------------------------------------------------------
    always_comb begin
        acc_ext = SW'(acc_q);
        act_v   = (act_q && acc_ext[SW-1]) ? '0 : acc_ext;
        if (act_v > SAT_MAX) begin
            sat_v = SAT_MAX[OUT_W-1:0];
        end else if (act_v < SAT_MIN) begin
            sat_v = SAT_MIN[OUT_W-1:0];
        end else begin
            sat_v = act_v[OUT_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        fsize_d    = fsize_q;
        pad_d      = pad_q;
        act_d      = act_q;
        n_d        = n_q;
        fi_d       = fi_q;
        fj_d       = fj_q;
        fdone_d    = fdone_q;
        lr_d       = lr_q;
        lc_d       = lc_q;
        r_d        = r_q;
        c_d        = c_q;
        issued_d   = issued_q;
        s1_valid_d = 1'b0;
        acc_d      = acc_q;
        filt_clr   = 1'b0;
        filt_we    = 1'b0;
        filt_wi    = '0;
        filt_wj    = '0;
        img_we     = 1'b0;
        img_wr     = '0;
        img_wc     = '0;

        case (state_q)
            S_IDLE: begin
                if (filter_valid) begin
                    fsize_d  = filter_size;
                    n_d      = n_clamp;
                    pad_d    = pad_mode;
                    act_d    = act_mode;
                    // Clear so coefficients never received read as zero
                    filt_clr = 1'b1;
                    filt_we  = 1'b1;
                    fi_d     = '0;
                    fj_d     = 3'd1;
                    fdone_d  = 1'b0;
                    state_d  = S_FILTER;
                end
            end

            S_FILTER: begin
                if (filter_valid && !fdone_q) begin
                    filt_we = 1'b1;
                    filt_wi = fi_q;
                    filt_wj = fj_q;
                    if (fj_q == k_last) begin
                        fj_d = '0;
                        if (fi_q == k_last) begin
                            fdone_d = 1'b1;
                        end else begin
                            fi_d = fi_q + 3'd1;
                        end
                    end else begin
                        fj_d = fj_q + 3'd1;
                    end
                end
                if (image_valid) begin
                    img_we  = 1'b1;
                    lr_d    = '0;
                    lc_d    = RW'(1);
                    state_d = S_IMAGE;
                end
            end

            S_IMAGE: begin
                if (image_valid) begin
                    img_we = 1'b1;
                    img_wr = lr_q;
                    img_wc = lc_q;
                    if ((lr_q == n_last) && (lc_q == n_last)) begin
                        r_d      = '0;
                        c_d      = '0;
                        issued_d = 1'b0;
                        state_d  = S_COMPUTE;
                    end else if (lc_q == n_last) begin
                        lc_d = '0;
                        lr_d = lr_q + RW'(1);
                    end else begin
                        lc_d = lc_q + RW'(1);
                    end
                end
            end

            S_COMPUTE: begin
                if (!issued_q) begin
                    s1_valid_d = 1'b1;
                    acc_d      = win_sum;
                    if (c_q == n_last) begin
                        c_d = '0;
                        if (r_q == n_last) begin
                            issued_d = 1'b1;
                        end else begin
                            r_d = r_q + RW'(1);
                        end
                    end else begin
                        c_d = c_q + RW'(1);
                    end
                end else if (!s1_valid_q && out_valid_q) begin
                    // Final result is on the output this cycle; leave
                    // COMPUTE together with out_valid dropping.
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        out_valid_d = s1_valid_q;
        out_data_d  = s1_valid_q ? sat_v : out_data_q;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            fsize_q     <= 1'b0;
            pad_q       <= 1'b0;
            act_q       <= 1'b0;
            n_q         <= NW'(3);
            fi_q        <= '0;
            fj_q        <= '0;
            fdone_q     <= 1'b0;
            lr_q        <= '0;
            lc_q        <= '0;
            r_q         <= '0;
            c_q         <= '0;
            issued_q    <= 1'b0;
            s1_valid_q  <= 1'b0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            fsize_q     <= fsize_d;
            pad_q       <= pad_d;
            act_q       <= act_d;
            n_q         <= n_d;
            fi_q        <= fi_d;
            fj_q        <= fj_d;
            fdone_q     <= fdone_d;
            lr_q        <= lr_d;
            lc_q        <= lc_d;
            r_q         <= r_d;
            c_q         <= c_d;
            issued_q    <= issued_d;
            s1_valid_q  <= s1_valid_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 5; i++) begin
                for (int unsigned j = 0; j < 5; j++) begin
                    filt_q[i][j] <= '0;
                end
            end
            for (int unsigned i = 0; i < MAX_N; i++) begin
                for (int unsigned j = 0; j < MAX_N; j++) begin
                    image_q[i][j] <= '0;
                end
            end
        end else begin
            if (filt_clr) begin
                for (int unsigned i = 0; i < 5; i++) begin
                    for (int unsigned j = 0; j < 5; j++) begin
                        filt_q[i][j] <= '0;
                    end
                end
            end
            // Later assignment wins over the clear for coefficient 0
            if (filt_we) begin
                filt_q[filt_wi][filt_wj] <= in_data;
            end
            if (img_we) begin
                image_q[img_wr][img_wc] <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_conv2d_engine.sv
module tb_conv2d_engine;

    localparam int DATA_W = 8;
    localparam int MAX_N  = 8;
    localparam int OUT_W  = 16;
    localparam int NW     = $clog2(MAX_N + 1);

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     filter_valid;
    logic                     image_valid;
    logic                     filter_size;
    logic [NW-1:0]            image_size;
    logic                     pad_mode;
    logic                     act_mode;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic signed [OUT_W-1:0]  out_data;

    always #5 clk = ~clk;

    conv2d_engine #(
        .DATA_W(DATA_W),
        .MAX_N (MAX_N),
        .OUT_W (OUT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .filter_valid(filter_valid),
        .image_valid (image_valid),
        .filter_size (filter_size),
        .image_size  (image_size),
        .pad_mode    (pad_mode),
        .act_mode    (act_mode),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_data    (out_data)
    );

    int checks   = 0;
    int failures = 0;

    int coef [25];
    int pix  [64];
    logic signed [OUT_W-1:0] got [64];
    int got_n;
    int first_k;
    int last_k;
    bit timed_out;

    // Inputs change on the falling edge; the DUT samples on the rising edge.
    task automatic send_job(input bit fs, input int nsz, input bit pm, input bit am,
                            input int ncoef, input int npix, input bit gaps);
        for (int i = 0; i < ncoef; i++) begin
            filter_valid = 1'b1;
            filter_size  = fs;
            image_size   = NW'(nsz);
            pad_mode     = pm;
            act_mode     = am;
            in_data      = DATA_W'(coef[i]);
            @(negedge clk);
            filter_valid = 1'b0;
            if (gaps) @(negedge clk);
        end
        for (int i = 0; i < npix; i++) begin
            image_valid = 1'b1;
            in_data     = DATA_W'(pix[i]);
            @(negedge clk);
            image_valid = 1'b0;
            if (gaps && i != npix - 1) @(negedge clk);
        end
    endtask

    // Samples at falling edges; k=1 is the first falling edge after the
    // rising edge that stored the last pixel. Stops on the first low
    // sample after the burst, leaving time at that falling edge.
    task automatic collect(input int budget);
        got_n     = 0;
        first_k   = -1;
        last_k    = -1;
        timed_out = 1'b1;
        for (int k = 1; k <= budget; k++) begin
            if (out_valid === 1'b1) begin
                if (first_k < 0) first_k = k;
                last_k = k;
                if (got_n < 64) got[got_n] = out_data;
                got_n++;
            end else if (first_k >= 0) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        filter_valid = 1'b0;
        image_valid  = 1'b0;
        filter_size  = 1'b0;
        image_size   = '0;
        pad_mode     = 1'b0;
        act_mode     = 1'b0;
        in_data      = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (out_data !== '0) begin
            failures++;
            $display("FAIL reset_data got=%0d exp=0", out_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero_pad();
        int exp_v[9] = '{12, 21, 16, 27, 45, 33, 24, 39, 28};
        for (int i = 0; i < 9; i++) begin
            coef[i] = 1;
            pix[i]  = i + 1;
        end
        send_job(1'b0, 3, 1'b0, 1'b0, 9, 9, 1'b0);
        collect(60);
        checks++;
        if (timed_out || got_n != 9) begin
            failures++;
            $display("FAIL zp_count got=%0d exp=9 timeout=%0b", got_n, timed_out);
        end
        checks++;
        if (last_k - first_k + 1 != got_n) begin
            failures++;
            $display("FAIL zp_contig span=%0d exp=%0d", last_k - first_k + 1, got_n);
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (got[i] !== OUT_W'(exp_v[i])) begin
                failures++;
                $display("FAIL zp_out[%0d] got=%0d exp=%0d", i, got[i], exp_v[i]);
            end
        end
        checks++;
        if (out_data !== OUT_W'(28)) begin
            failures++;
            $display("FAIL zp_hold got=%0d exp=28", out_data);
        end
    endtask

    task automatic test_replicate();
        int exp_v[9] = '{21, 27, 33, 39, 45, 51, 57, 63, 69};
        for (int i = 0; i < 9; i++) begin
            coef[i] = 1;
            pix[i]  = i + 1;
        end
        send_job(1'b0, 3, 1'b1, 1'b0, 9, 9, 1'b0);
        collect(60);
        checks++;
        if (timed_out || got_n != 9) begin
            failures++;
            $display("FAIL rep_count got=%0d exp=9 timeout=%0b", got_n, timed_out);
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (got[i] !== OUT_W'(exp_v[i])) begin
                failures++;
                $display("FAIL rep_out[%0d] got=%0d exp=%0d", i, got[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_relu();
        int exp_v[9] = '{-12, -21, -16, -27, -45, -33, -24, -39, -28};
        for (int i = 0; i < 9; i++) begin
            coef[i] = -1;
            pix[i]  = i + 1;
        end
        // image_size 1 is clamped to 3
        send_job(1'b0, 1, 1'b0, 1'b1, 9, 9, 1'b0);
        collect(60);
        checks++;
        if (timed_out || got_n != 9) begin
            failures++;
            $display("FAIL relu_count got=%0d exp=9 timeout=%0b", got_n, timed_out);
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (got[i] !== '0) begin
                failures++;
                $display("FAIL relu_out[%0d] got=%0d exp=0", i, got[i]);
            end
        end
        send_job(1'b0, 3, 1'b0, 1'b0, 9, 9, 1'b0);
        collect(60);
        checks++;
        if (timed_out || got_n != 9) begin
            failures++;
            $display("FAIL neg_count got=%0d exp=9 timeout=%0b", got_n, timed_out);
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (got[i] !== OUT_W'(exp_v[i])) begin
                failures++;
                $display("FAIL neg_out[%0d] got=%0d exp=%0d", i, got[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 25; i++) begin
            coef[i] = -128;
            pix[i]  = -128;
        end
        send_job(1'b1, 5, 1'b1, 1'b0, 25, 25, 1'b0);
        collect(100);
        checks++;
        if (timed_out || got_n != 25) begin
            failures++;
            $display("FAIL satp_count got=%0d exp=25 timeout=%0b", got_n, timed_out);
        end
        for (int i = 0; i < 25; i++) begin
            checks++;
            if (got[i] !== OUT_W'(32767)) begin
                failures++;
                $display("FAIL satp_out[%0d] got=%0d exp=32767", i, got[i]);
            end
        end
        for (int i = 0; i < 25; i++) pix[i] = 127;
        send_job(1'b1, 5, 1'b1, 1'b0, 25, 25, 1'b0);
        collect(100);
        checks++;
        if (timed_out || got_n != 25) begin
            failures++;
            $display("FAIL satn_count got=%0d exp=25 timeout=%0b", got_n, timed_out);
        end
        for (int i = 0; i < 25; i++) begin
            checks++;
            if (got[i] !== OUT_W'(-32768)) begin
                failures++;
                $display("FAIL satn_out[%0d] got=%0d exp=-32768", i, got[i]);
            end
        end
    endtask

    // Only five coefficients are sent; the rest must read as zero even
    // though the previous job left -128 everywhere.
    task automatic test_gaps_latency();
        coef[0] = 0; coef[1] = 0; coef[2] = 0; coef[3] = 0; coef[4] = 1;
        for (int i = 0; i < 16; i++) pix[i] = i * 9 - 70;
        send_job(1'b0, 4, 1'b0, 1'b0, 5, 16, 1'b1);
        collect(80);
        checks++;
        if (timed_out || got_n != 16) begin
            failures++;
            $display("FAIL gap_count got=%0d exp=16 timeout=%0b", got_n, timed_out);
        end
        checks++;
        if (first_k - 1 != 2) begin
            failures++;
            $display("FAIL gap_latency got=%0d exp=2", first_k - 1);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got[i] !== OUT_W'(pix[i])) begin
                failures++;
                $display("FAIL gap_out[%0d] got=%0d exp=%0d", i, got[i], pix[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        int exp_v[9] = '{12, 21, 16, 27, 45, 33, 24, 39, 28};
        int seen;
        for (int i = 0; i < 9; i++) begin
            coef[i] = 1;
            pix[i]  = i + 1;
        end
        send_job(1'b0, 3, 1'b0, 1'b0, 9, 9, 1'b0);
        seen = 0;
        for (int k = 0; k < 40 && seen < 3; k++) begin
            if (out_valid === 1'b1) seen++;
            if (seen < 3) @(negedge clk);
        end
        checks++;
        if (seen != 3) begin
            failures++;
            $display("FAIL mr_start got=%0d exp=3", seen);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL mr_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (out_data !== '0) begin
            failures++;
            $display("FAIL mr_data got=%0d exp=0", out_data);
        end
        rst_n = 1'b1;
        seen  = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL mr_partial got=%0d exp=0", seen);
        end
        send_job(1'b0, 3, 1'b0, 1'b0, 9, 9, 1'b0);
        collect(60);
        checks++;
        if (timed_out || got_n != 9) begin
            failures++;
            $display("FAIL mr_count got=%0d exp=9 timeout=%0b", got_n, timed_out);
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (got[i] !== OUT_W'(exp_v[i])) begin
                failures++;
                $display("FAIL mr_out[%0d] got=%0d exp=%0d", i, got[i], exp_v[i]);
            end
        end
    endtask

    // Job B's first coefficient is driven on the cycle right after job A's
    // final result. Job A carries a 10th coefficient that must be ignored.
    task automatic test_back_to_back();
        int exp_a[9] = '{12, 21, 16, 27, 45, 33, 24, 39, 28};
        int exp_b[9] = '{21, 27, 33, 39, 45, 51, 57, 63, 69};
        for (int i = 0; i < 9; i++) begin
            coef[i] = 1;
            pix[i]  = i + 1;
        end
        coef[9] = 100;
        send_job(1'b0, 3, 1'b0, 1'b0, 10, 9, 1'b0);
        collect(60);
        checks++;
        if (timed_out || got_n != 9) begin
            failures++;
            $display("FAIL b2b_a_count got=%0d exp=9 timeout=%0b", got_n, timed_out);
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (got[i] !== OUT_W'(exp_a[i])) begin
                failures++;
                $display("FAIL b2b_a_out[%0d] got=%0d exp=%0d", i, got[i], exp_a[i]);
            end
        end
        send_job(1'b0, 3, 1'b1, 1'b0, 9, 9, 1'b0);
        collect(60);
        checks++;
        if (timed_out || got_n != 9) begin
            failures++;
            $display("FAIL b2b_b_count got=%0d exp=9 timeout=%0b", got_n, timed_out);
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (got[i] !== OUT_W'(exp_b[i])) begin
                failures++;
                $display("FAIL b2b_b_out[%0d] got=%0d exp=%0d", i, got[i], exp_b[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_pad();
        test_replicate();
        test_relu();
        test_saturation();
        test_gaps_latency();
        test_mid_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv2d_engine.md
Name: conv2d_engine

Overview:
- Parametrised 2-D "same" convolution engine. Loads a KxK signed filter (K = 3 or 5) and an NxN signed image, then streams NxN activated, saturated results in raster order.
- Generalises the fixed Conv block with configurable data/output widths and maximum image size.
- Adds replicate padding and output saturation.
- Sits between the input sample stream and the downstream result collector.

Parameters:
- DATA_W, 8: width of signed in_data samples and filter coefficients.
- MAX_N, 8: largest supported image side (minimum supported side is 3).
- OUT_W, 16: width of signed out_data; results are saturated to this width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- filter_valid  input  1  qualifies in_data as a filter coefficient.
- image_valid  input  1  qualifies in_data as an image pixel.
- filter_size  input  1  0 = 3x3, 1 = 5x5; sampled with the first filter coefficient.
- image_size  input  $clog2(MAX_N+1)  image side N; sampled with the first filter coefficient.
- pad_mode  input  1  0 = zero padding, 1 = replicate (edge clamp); sampled with the first coefficient.
- act_mode  input  1  0 = pass-through, 1 = ReLU; sampled with the first coefficient.
- in_data  input  DATA_W  signed sample.
- out_valid  output  1  qualifies out_data.
- out_data  output  OUT_W  signed convolution result.

Behaviour:
- Reset (rst_n low at a rising edge):
  - state = IDLE; out_valid = 0; out_data = 0.
  - All counters = 0; filter and image buffers cleared to 0.
- States: IDLE -> FILTER -> IMAGE -> COMPUTE -> IDLE.
- IDLE:
  - First cycle with filter_valid=1 latches filter_size, image_size, pad_mode and act_mode.
  - The same cycle stores coefficient 0; go to FILTER.
  - image_valid is ignored in IDLE.
- FILTER:
  - Each filter_valid cycle stores the next coefficient in row-major order; gaps (filter_valid=0) are allowed.
  - Coefficients beyond K*K are ignored; any not received remain 0.
  - The first image_valid=1 cycle stores pixel 0 and moves to IMAGE.
- IMAGE:
  - Each image_valid cycle stores the next pixel in row-major order; gaps are allowed.
  - The cycle storing pixel N*N-1 moves to COMPUTE.
  - filter_valid is ignored in IMAGE.
- COMPUTE:
  - One output per cycle in raster order (r, c), r and c in 0..N-1.
  - First out_valid=1 occurs on the 2nd rising edge after the edge that stored the last pixel.
  - out_valid stays high for exactly N*N consecutive cycles, then returns to 0 and the state to IDLE.
  - All inputs are ignored in COMPUTE.
- Latched image_size clamping: values below 3 are treated as 3; values above MAX_N are treated as MAX_N.
- Window: centred at (r, c) with offset h = K/2; tap (i, j) reads pixel (r+i-h, c+j-h).
  - pad_mode=0: out-of-range coordinates read 0.
  - pad_mode=1: each out-of-range coordinate is clamped to [0, N-1] independently.
- Arithmetic:
  - Products are full precision (2*DATA_W bits, signed).
  - The sum is accumulated at 2*DATA_W+5 bits, so no internal overflow occurs.
  - Activation is applied next: ReLU maps negative values to 0.
  - The result is then saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- out_data holds its last value when out_valid=0.
- Reset mid-operation: the operation is aborted immediately.
  - out_valid drops on that edge; no partial results are emitted.
  - The next job starts from IDLE with cleared buffers.
- Back-to-back jobs: filter_valid on the cycle after the final out_valid is accepted as the start of a new job.

Test Plan:
- 3x3 filter all 1, N=3, pixels 1..9, pad_mode=0, act_mode=0 -> 9 outputs 12,21,16,27,45,33,24,39,28; out_valid contiguous for 9 cycles.
- Same stimulus with pad_mode=1 -> first output 21, centre 45, last output 69.
- Filter all -1, N=3, pixels 1..9, act_mode=1 -> all 9 outputs 0. Repeat with act_mode=0 -> centre output -45.
- 5x5 filter all -128, N=5, all pixels -128, pad_mode=1 -> all 25 outputs saturate to 32767 (OUT_W=16).
- filter_valid and image_valid with 1-cycle gaps inserted, N=4, 3x3 identity filter (centre 1) -> outputs equal the input pixels in order; latency measured from the last stored pixel is exactly 2 edges.
- Assert rst_n=0 for one cycle mid-COMPUTE -> out_valid=0 the next cycle. A following full 3x3/N=3 job then produces the same results as scenario 1.
